// File: rtl/input_pkg.sv
// Shared constants and types for the board input path (button conditioning and input manager).
package input_pkg;

  localparam int BTN_DB_CYCLES     = 1_000_000;   // 10 ms at 100 MHz
  localparam int BTN_REPEAT_DELAY  = 25_000_000;  // 250 ms before the first repeat
  localparam int BTN_REPEAT_PERIOD = 5_000_000;   // 50 ms between repeats

  typedef enum logic [1:0] {
    REP_OFF,
    REP_DELAY,
    REP_RATE
  } rep_state_t;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: synchroniser, stable-time debounce counter and registered press/release pulses.
// Defining BTN_AUTOREPEAT_EN adds the per-channel auto-repeat FSM; otherwise repeat_o is tied low.
module btn_debounce_chan
  import input_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = BTN_DB_CYCLES,
  parameter int REPEAT_DELAY  = BTN_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = BTN_REPEAT_PERIOD
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, press_q, release_q;
  logic                   sample, differ, accept;

  assign sample = sync_q[SYNC_STAGES-1];
  assign differ = (sample != level_q);
  // The differing cycle that would bring the count to DB_CYCLES is the accepting one.
  assign accept = differ && (cnt_q == CW'(DB_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    if (differ && !accept) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q     <= cnt_d;
      press_q   <= accept && sample;
      release_q <= accept && !sample;
      if (accept) level_q <= sample;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  rep_state_t    rep_q;
  logic [RW-1:0] rcnt_q;
  logic          repeat_q;

  // Keyed off the accept event rather than press_q so the first repeat lands exactly
  // REPEAT_DELAY edges after the press pulse.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      rep_q    <= REP_OFF;
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (accept && !sample) begin
        rep_q  <= REP_OFF;
        rcnt_q <= '0;
      end else begin
        case (rep_q)
          REP_OFF: begin
            if (accept && sample) begin
              rep_q  <= REP_DELAY;
              rcnt_q <= '0;
            end
          end
          REP_DELAY: begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              repeat_q <= 1'b1;
              rcnt_q   <= '0;
              rep_q    <= REP_RATE;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          REP_RATE: begin
            if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
              repeat_q <= 1'b1;
              rcnt_q   <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            rep_q  <= REP_OFF;
            rcnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel push-button conditioner: one independent btn_debounce_chan per pin.
// Auto-repeat is present only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_array
  import input_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = BTN_DB_CYCLES,
  parameter int REPEAT_DELAY  = BTN_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = BTN_REPEAT_PERIOD
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    btn_debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .CLK100MHZ(CLK100MHZ),
      .rst      (rst),
      .btn_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Self-checking bench for btn_debounce_array: window-based reference model plus directed literal checks.
module tb_btn_debounce_array;

  localparam int CH   = 3;
  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int RD   = 20;
  localparam int RP   = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          CLK100MHZ = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_debounce_array #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SYNC),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a change is accepted when the last DB synchronised samples all
  // differ from the current level; repeats fall at press_edge + RD + n*RP while held.
  logic [CH-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
  bit            m_valid = 1'b0;
  int            ec = 0;
  int            pedge[CH];
  logic          pins[CH][$];
  logic          sq[CH][$];

  always @(posedge CLK100MHZ) begin
    logic s;
    bit   all_diff;
    ec++;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        pins[c].delete();
        sq[c].delete();
        m_level[c]   = 1'b0;
        m_press[c]   = 1'b0;
        m_release[c] = 1'b0;
        m_repeat[c]  = 1'b0;
        pedge[c]     = -1;
      end else begin
        s = (pins[c].size() >= SYNC) ? pins[c][pins[c].size()-SYNC] : 1'b0;
        pins[c].push_back(btn_in[c]);
        if (pins[c].size() > SYNC) void'(pins[c].pop_front());
        sq[c].push_back(s);
        if (sq[c].size() > DB) void'(sq[c].pop_front());
        all_diff = (sq[c].size() == DB);
        for (int j = 0; j < sq[c].size(); j++)
          if (sq[c][j] == m_level[c]) all_diff = 1'b0;
        m_press[c]   = all_diff && s;
        m_release[c] = all_diff && !s;
        if (all_diff) m_level[c] = s;
        if (m_press[c]) pedge[c] = ec;
        if (m_release[c]) pedge[c] = -1;
        m_repeat[c] = REP_EN && m_level[c] && (pedge[c] >= 0) && ((ec - pedge[c]) >= RD)
                      && (((ec - pedge[c] - RD) % RP) == 0);
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (m_valid) begin
      check("model_level",   btn_level,   m_level);
      check("model_press",   btn_press,   m_press);
      check("model_release", btn_release, m_release);
      check("model_repeat",  btn_repeat,  m_repeat);
    end
  end

  int press_hits[$], rel_hits[$], rep_hits[$];

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic watch(input int n, input int ch);
    press_hits.delete();
    rel_hits.delete();
    rep_hits.delete();
    for (int k = 1; k <= n; k++) begin
      tick();
      if (btn_press[ch])   press_hits.push_back(k);
      if (btn_release[ch]) rel_hits.push_back(k);
      if (btn_repeat[ch])  rep_hits.push_back(k);
    end
  endtask

  task automatic expect_hits(input string name, input int sel, input int n,
                             input int e0, input int e1, input int e2);
    int q[$];
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    case (sel)
      0:       q = press_hits;
      1:       q = rel_hits;
      default: q = rep_hits;
    endcase
    check({name, "_count"}, q.size(), n);
    for (int i = 0; i < n; i++) check(name, (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit_cnt;
    int hit_edge;

    // Reset state
    tick();
    m_valid = 1'b1;
    tick();
    check("rst_level",   btn_level,   0);
    check("rst_press",   btn_press,   0);
    check("rst_release", btn_release, 0);
    check("rst_repeat",  btn_repeat,  0);

    // Clean press on ch0, held long enough to see the repeat train
    rst = 1'b0;
    btn_in[0] = 1'b1;
    watch(45, 0);
    expect_hits("press0_edge", 0, 1, 10, 0, 0);
    expect_hits("repeat0_edges", 2, REP_EN ? 3 : 0, 30, 35, 40);
    check("others_idle", btn_level[2:1], 0);

    // Bounce on ch1: 7 high, 1 low, then high
    hit_cnt = 0;
    hit_edge = -1;
    for (int k = 1; k <= 30; k++) begin
      btn_in[1] = (k != 8);
      tick();
      if (btn_press[1]) begin
        hit_cnt++;
        hit_edge = k;
      end
    end
    check("bounce1_count", hit_cnt, 1);
    check("bounce1_edge", hit_edge, 18);

    // Release ch0
    btn_in[0] = 1'b0;
    watch(14, 0);
    expect_hits("release0_edge", 1, 1, 10, 0, 0);
    check("release0_level", btn_level[0], 0);

    // ch2: press then release while still in the repeat delay
    btn_in[2] = 1'b1;
    watch(12, 2);
    expect_hits("press2_edge", 0, 1, 10, 0, 0);
    btn_in[2] = 1'b0;
    watch(30, 2);
    expect_hits("release2_edge", 1, 1, 10, 0, 0);
    expect_hits("repeat2_none", 2, 0, 0, 0, 0);

    btn_in[1] = 1'b0;
    watch(12, 1);
    expect_hits("release1_edge", 1, 1, 10, 0, 0);

    // Reset in the middle of a press count, pin held high throughout
    btn_in[0] = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 0);
    end
    rst = 1'b0;
    watch(14, 0);
    expect_hits("postrst_press", 0, 1, 10, 0, 0);
    btn_in[0] = 1'b0;
    watch(14, 0);
    expect_hits("postrst_release", 1, 1, 10, 0, 0);

    // Simultaneous press on all channels, then staggered releases
    btn_in = '1;
    hit_cnt = 0;
    hit_edge = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (btn_press != 0) hit_cnt++;
      if (btn_press == 3'b111) hit_edge = k;
    end
    check("all_press_cycles", hit_cnt, 1);
    check("all_press_edge", hit_edge, 10);

    begin
      int rel_edge[CH];
      for (int c = 0; c < CH; c++) rel_edge[c] = -1;
      for (int k = 1; k <= 20; k++) begin
        if (k == 1) btn_in[0] = 1'b0;
        if (k == 4) btn_in[1] = 1'b0;
        if (k == 7) btn_in[2] = 1'b0;
        tick();
        for (int c = 0; c < CH; c++) if (btn_release[c]) rel_edge[c] = k;
      end
      check("stagger_rel0", rel_edge[0], 10);
      check("stagger_rel1", rel_edge[1], 13);
      check("stagger_rel2", rel_edge[2], 16);
    end
    check("final_level", btn_level, 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised N-channel push-button conditioner for the board's mechanical buttons. It replaces the fixed two-input debouncer and sits between the raw button pins and the input manager. Each channel synchronises its pin, debounces it with a programmable stable-time counter, and emits a clean level plus one-cycle press and release pulses. An optional per-channel auto-repeat pulse stream is also available.

## Interface
- CHANNELS, 5, number of independent button channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DB_CYCLES, 1_000_000, consecutive differing cycles required to accept a change (10 ms at 100 MHz; ≥2)
- REPEAT_DELAY, 25_000_000, cycles from press pulse to first repeat pulse (≥1)
- REPEAT_PERIOD, 5_000_000, cycles between subsequent repeat pulses (≥1)

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- btn_in  in  CHANNELS  raw asynchronous button pins, active-high
- btn_level  out  CHANNELS  debounced level
- btn_press  out  CHANNELS  one-cycle pulse on each accepted 0→1 change
- btn_release  out  CHANNELS  one-cycle pulse on each accepted 1→0 change
- btn_repeat  out  CHANNELS  auto-repeat pulses while held (constant 0 when the feature is compiled out)

## Operation
- Channels are fully independent; no shared state except clock and reset.
- Synchroniser: btn_in[i] shifts through SYNC_STAGES flops; the last flop is the channel's sample s.
- Debounce: counter cnt. If s == btn_level: cnt <= 0. Otherwise cnt increments. When a differing cycle would bring cnt to DB_CYCLES, then btn_level <= s, cnt <= 0, and the matching press/release pulse is asserted for exactly that cycle.
- Glitches shorter than DB_CYCLES differing cycles never change btn_level. Any matching sample restarts the count from 0.
- cnt width is $clog2(DB_CYCLES+1). It never exceeds DB_CYCLES.
- Repeat FSM per channel (when enabled), with states OFF, DELAY, RATE:
  - OFF→DELAY on btn_press, loading rcnt <= 0.
  - DELAY: rcnt increments; at rcnt == REPEAT_DELAY-1, pulse btn_repeat, rcnt <= 0, go to RATE.
  - RATE: at rcnt == REPEAT_PERIOD-1, pulse btn_repeat, rcnt <= 0.
  - Any state→OFF on btn_release, same cycle, with no repeat pulse in that cycle.
- btn_press and btn_repeat are never high in the same cycle.

## Timing
- Reset: all synchroniser flops, cnt, rcnt, btn_level, btn_press, btn_release, btn_repeat are 0; FSM is OFF.
- Reset mid-bounce or mid-repeat discards all progress.
- A button held through reset is reported as a fresh press after the normal latency.
- Latency: btn_in stable before edge 1 → btn_level/btn_press (or btn_release) update at edge SYNC_STAGES+DB_CYCLES.
- Repeat: press pulse at edge P → repeats at P+REPEAT_DELAY, then every REPEAT_PERIOD edges while btn_level stays 1.
- All outputs are registered; there is no combinational path from btn_in.

## Configuration
- BTN_AUTOREPEAT_EN defined: repeat FSM and rcnt are instantiated per channel; btn_repeat behaves as above.
- BTN_AUTOREPEAT_EN undefined: no repeat logic; btn_repeat is tied to 0; REPEAT_* parameters are ignored.

## Structure
- Shared package input_pkg holds:
  - default constants BTN_DB_CYCLES, BTN_REPEAT_DELAY, BTN_REPEAT_PERIOD;
  - the repeat-state enum typedef rep_state_t {REP_OFF, REP_DELAY, REP_RATE}.
- Sub-module btn_debounce_chan implements one channel (synchroniser, debounce counter, optional repeat FSM). It is instantiated CHANNELS times in a generate loop.

## Test plan
Bench parameters: SYNC_STAGES=2, DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, CHANNELS=3.
- Clean press: btn_in[0] 0→1 before edge 1 → btn_level[0]=1 and btn_press[0] pulse at edge 10; other channels stay 0.
- Bounce rejection: btn_in[1] high for 7 cycles, low for 1, high again → no press until 8 consecutive high samples; exactly one press pulse.
- Release: held channel drops to 0 → btn_release one-cycle pulse 10 edges later; btn_level=0.
- Auto-repeat (BTN_AUTOREPEAT_EN): press at edge 10, hold → btn_repeat at edges 30, 35, 40; release during DELAY → zero repeats.
- Reset mid-operation: rst asserted at edge 5 of a press count while btn_in stays high → all outputs 0 during rst; press pulse exactly SYNC_STAGES+DB_CYCLES edges after rst deasserts.
- Simultaneous channels: all three pins rise together → three press pulses in the same cycle; staggered releases are reported independently.
